// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin front end that lets two requesters share one ALU.
// A request is accepted in IDLE, its operands are latched onto the ALU ports,
// and the result (or an error) is handed back to the owner with a done pulse.
// Divide-by-zero is answered without touching the ALU, and a counter bounds
// how long the ALU may take before the operation is aborted with an error.

module alu_arbiter #(
   parameter int IN_SIZE = 4,
   parameter int TIMEOUT = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req0,
   input  logic                   req1,
   input  logic [1:0]             op0,
   input  logic [1:0]             op1,
   input  logic [IN_SIZE-1:0]     a0,
   input  logic [IN_SIZE-1:0]     b0,
   input  logic [IN_SIZE-1:0]     a1,
   input  logic [IN_SIZE-1:0]     b1,
   output logic                   gnt0,
   output logic                   gnt1,
   output logic                   done0,
   output logic                   done1,
   output logic [2*IN_SIZE-1:0]   res0,
   output logic [2*IN_SIZE-1:0]   res1,
   output logic                   err0,
   output logic                   err1,
   output logic                   busy,
   output logic                   alu_en,
   output logic [1:0]             alu_op,
   output logic [IN_SIZE-1:0]     alu_a,
   output logic [IN_SIZE-1:0]     alu_b,
   input  logic [2*IN_SIZE-1:0]   alu_result,
   input  logic                   alu_valid
);

   localparam int CW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
   localparam logic [1:0] OP_DIV = 2'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t              state;
   logic                last;
   logic                owner;
   logic [CW-1:0]       cnt;

   logic                any_req;
   logic                pick;
   logic [1:0]          sel_op;
   logic [IN_SIZE-1:0]  sel_a;
   logic [IN_SIZE-1:0]  sel_b;
   logic                div_zero;

   // Choose the winner of this IDLE cycle: a lone requester wins outright,
   // a tie goes to whichever requester was not served last.
   always_comb begin
      any_req  = req0 | req1;
      pick     = 1'b0;
      if (req0 && req1) begin
         pick = ~last;
      end else if (req1) begin
         pick = 1'b1;
      end
      sel_op   = pick ? op1 : op0;
      sel_a    = pick ? a1  : a0;
      sel_b    = pick ? b1  : b0;
      div_zero = (sel_op == OP_DIV) && (sel_b == '0);
   end

   // Controller FSM; every output is a register so the pulses and ALU port
   // values line up exactly with the state they belong to.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         last   <= 1'b1;
         owner  <= 1'b0;
         cnt    <= '0;
         gnt0   <= 1'b0;
         gnt1   <= 1'b0;
         done0  <= 1'b0;
         done1  <= 1'b0;
         res0   <= '0;
         res1   <= '0;
         err0   <= 1'b0;
         err1   <= 1'b0;
         busy   <= 1'b0;
         alu_en <= 1'b0;
         alu_op <= '0;
         alu_a  <= '0;
         alu_b  <= '0;
      end else begin
         gnt0  <= 1'b0;
         gnt1  <= 1'b0;
         done0 <= 1'b0;
         done1 <= 1'b0;
         res0  <= '0;
         res1  <= '0;
         err0  <= 1'b0;
         err1  <= 1'b0;

         case (state)
            IDLE: begin
               if (any_req) begin
                  last  <= pick;
                  owner <= pick;
                  gnt0  <= ~pick;
                  gnt1  <= pick;
                  busy  <= 1'b1;
                  cnt   <= '0;
                  if (div_zero) begin
                     state <= RESP;
                     done0 <= ~pick;
                     done1 <= pick;
                     err0  <= ~pick;
                     err1  <= pick;
                  end else begin
                     state  <= EXEC;
                     alu_en <= 1'b1;
                     alu_op <= sel_op;
                     alu_a  <= sel_a;
                     alu_b  <= sel_b;
                  end
               end
            end

            EXEC: begin
               cnt <= cnt + CW'(1);
               if ((cnt != '0) && alu_valid) begin
                  state  <= RESP;
                  alu_en <= 1'b0;
                  alu_op <= '0;
                  alu_a  <= '0;
                  alu_b  <= '0;
                  done0  <= ~owner;
                  done1  <= owner;
                  if (owner) begin
                     res1 <= alu_result;
                  end else begin
                     res0 <= alu_result;
                  end
               end else if (cnt == CNT_LAST) begin
                  state  <= RESP;
                  alu_en <= 1'b0;
                  alu_op <= '0;
                  alu_a  <= '0;
                  alu_b  <= '0;
                  done0  <= ~owner;
                  done1  <= owner;
                  err0   <= ~owner;
                  err1   <= owner;
               end
            end

            RESP: begin
               state <= IDLE;
               busy  <= 1'b0;
            end

            default: begin
               state  <= IDLE;
               busy   <= 1'b0;
               alu_en <= 1'b0;
               alu_op <= '0;
               alu_a  <= '0;
               alu_b  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scenario tasks drive the two requesters, a small stand-in
// ALU answers the controller, and expected responses are queued when a
// request is presented and popped when the matching done pulse appears.

module tb_alu_arbiter;

   localparam int IN = 4;
   localparam int TO = 16;
   localparam int RW = 2 * IN;
   localparam int VW = 2 * RW + 4;

   logic          clk;
   logic          rst;
   logic          req0, req1;
   logic [1:0]    op0, op1;
   logic [IN-1:0] a0, b0, a1, b1;
   logic          gnt0, gnt1, done0, done1;
   logic [RW-1:0] res0, res1;
   logic          err0, err1, busy, alu_en;
   logic [1:0]    alu_op;
   logic [IN-1:0] alu_a, alu_b;
   logic [RW-1:0] alu_result;
   logic          alu_valid;

   int errors = 0;
   int checks = 0;
   int t = 0;

   int exec_idx = 0;
   int valid_at = 2;
   bit stale = 1'b0;

   typedef struct packed {
      logic          who;
      logic [RW-1:0] res;
      logic          err;
   } exp_t;

   exp_t sb[$];

   alu_arbiter #(.IN_SIZE(IN), .TIMEOUT(TO)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0       (req0),
      .req1       (req1),
      .op0        (op0),
      .op1        (op1),
      .a0         (a0),
      .b0         (b0),
      .a1         (a1),
      .b1         (b1),
      .gnt0       (gnt0),
      .gnt1       (gnt1),
      .done0      (done0),
      .done1      (done1),
      .res0       (res0),
      .res1       (res1),
      .err0       (err0),
      .err1       (err1),
      .busy       (busy),
      .alu_en     (alu_en),
      .alu_op     (alu_op),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_result (alu_result),
      .alu_valid  (alu_valid)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Absolute time limit so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [RW-1:0] alu_model(input logic [1:0] op, input logic [IN-1:0] a, input logic [IN-1:0] b);
      logic [RW-1:0] wa;
      logic [RW-1:0] wb;
      wa = RW'(a);
      wb = RW'(b);
      case (op)
         2'd0:    return wa + wb;
         2'd1:    return wa - wb;
         2'd2:    return wa * wb;
         default: return (wb == '0) ? '0 : wa / wb;
      endcase
   endfunction

   // Stand-in ALU: raises valid in the chosen EXEC cycle with the computed
   // result, optionally flashes a stale valid in the first cycle, and drives
   // junk on the result bus whenever it is not answering.
   always @(negedge clk) begin
      if (alu_en) exec_idx = exec_idx + 1;
      else        exec_idx = 0;
      if (alu_en && exec_idx == valid_at) begin
         alu_valid  = 1'b1;
         alu_result = alu_model(alu_op, alu_a, alu_b);
      end else if (alu_en && stale && exec_idx == 1) begin
         alu_valid  = 1'b1;
         alu_result = 8'hEE;
      end else begin
         alu_valid  = 1'b0;
         alu_result = 8'hEE;
      end
   end

   task automatic push_exp(input logic who, input logic [RW-1:0] r, input logic e);
      exp_t x;
      x.who = who;
      x.res = r;
      x.err = e;
      sb.push_back(x);
   endtask

   // Expected {done0,done1,res0,res1,err0,err1} for the oldest queued entry.
   function automatic logic [VW-1:0] pop_vec();
      exp_t e;
      if (sb.size() == 0) return '1;
      e = sb.pop_front();
      if (e.who) return {1'b0, 1'b1, {RW{1'b0}}, e.res, 1'b0, e.err};
      return {1'b1, 1'b0, e.res, {RW{1'b0}}, e.err, 1'b0};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      t++;
   endtask

   // Watch the DUT cycle by cycle until a done pulse or the cycle budget runs
   // out; a requester with drop set releases its req once it sees its grant.
   task automatic observe(input int limit, input bit drop, output int g_t, output int g_who,
                          output int d_t, output logic [VW-1:0] d_vec, output bit en_seen, output bit leak);
      g_t = -1;
      g_who = -1;
      d_t = -1;
      d_vec = '0;
      en_seen = 1'b0;
      leak = 1'b0;
      for (int i = 0; i < limit; i++) begin
         tick();
         if (alu_en) en_seen = 1'b1;
         if (g_t < 0 && (gnt0 || gnt1)) begin
            g_t = t;
            g_who = gnt1 ? 1 : 0;
         end
         if (drop && gnt0) req0 = 1'b0;
         if (drop && gnt1) req1 = 1'b0;
         if (done0 || done1) begin
            d_t = t;
            d_vec = {done0, done1, res0, res1, err0, err1};
            break;
         end
         if (res0 != '0 || res1 != '0 || err0 || err1) leak = 1'b1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      logic [VW+IN*2+4:0] outs;
      req0 = 1'b0; req1 = 1'b0;
      rst = 1'b0;
      #2;
      outs = {gnt0, gnt1, done0, done1, res0, res1, err0, err1, busy, alu_en, alu_op, alu_a, alu_b};
      checks++;
      if (outs !== '0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got %h expected 0", outs);
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      tick();
      tick();
      outs = {gnt0, gnt1, done0, done1, res0, res1, err0, err1, busy, alu_en, alu_op, alu_a, alu_b};
      checks++;
      if (outs !== '0) begin
         errors++;
         $display("[TB] FAIL idle_outputs: got %h expected 0", outs);
      end
   endtask

   task automatic test_single_add();
      int g_t, g_who, d_t;
      logic [VW-1:0] d_vec, e_vec;
      bit en_seen, leak;
      tick();
      stale = 1'b0; valid_at = 2;
      op0 = 2'd0; a0 = 4'd1; b0 = 4'd2;
      push_exp(1'b0, 8'd3, 1'b0);
      req0 = 1'b1;
      t = 0;
      observe(40, 1'b1, g_t, g_who, d_t, d_vec, en_seen, leak);
      checks++;
      if (g_t !== 1 || g_who !== 0) begin
         errors++;
         $display("[TB] FAIL add_grant: got t=%0d who=%0d expected t=1 who=0", g_t, g_who);
      end
      checks++;
      if (d_t !== 3) begin
         errors++;
         $display("[TB] FAIL add_done_time: got %0d expected 3", d_t);
      end
      e_vec = pop_vec();
      checks++;
      if (d_vec !== e_vec) begin
         errors++;
         $display("[TB] FAIL add_response: got %h expected %h", d_vec, e_vec);
      end
      checks++;
      if (leak !== 1'b0 || en_seen !== 1'b1) begin
         errors++;
         $display("[TB] FAIL add_side: got leak=%0d en=%0d expected leak=0 en=1", leak, en_seen);
      end
      tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL add_busy_after: got %0d expected 0", busy);
      end
   endtask

   task automatic test_simultaneous();
      int g_t, g_who, d_t, prev_d;
      logic [VW-1:0] d_vec, e_vec;
      bit en_seen, leak;
      do_reset();
      stale = 1'b0; valid_at = 2;
      op0 = 2'd2; a0 = 4'd7; b0 = 4'd4;
      op1 = 2'd1; a1 = 4'd8; b1 = 4'd1;
      push_exp(1'b0, 8'd28, 1'b0);
      push_exp(1'b1, 8'd7,  1'b0);
      push_exp(1'b0, 8'd28, 1'b0);
      push_exp(1'b1, 8'd7,  1'b0);
      req0 = 1'b1; req1 = 1'b1;
      t = 0;
      prev_d = -1;
      for (int k = 0; k < 4; k++) begin
         observe(40, 1'b0, g_t, g_who, d_t, d_vec, en_seen, leak);
         checks++;
         if (g_who !== (k % 2)) begin
            errors++;
            $display("[TB] FAIL tie_grant_order[%0d]: got %0d expected %0d", k, g_who, k % 2);
         end
         checks++;
         if (g_t !== ((k == 0) ? 1 : prev_d + 2)) begin
            errors++;
            $display("[TB] FAIL tie_grant_time[%0d]: got %0d expected %0d", k, g_t, (k == 0) ? 1 : prev_d + 2);
         end
         e_vec = pop_vec();
         checks++;
         if (d_vec !== e_vec) begin
            errors++;
            $display("[TB] FAIL tie_response[%0d]: got %h expected %h", k, d_vec, e_vec);
         end
         prev_d = d_t;
      end
      req0 = 1'b0; req1 = 1'b0;
   endtask

   task automatic test_div_zero();
      int g_t, g_who, d_t;
      logic [VW-1:0] d_vec, e_vec;
      bit en_seen, leak;
      tick();
      op1 = 2'd3; a1 = 4'd8; b1 = 4'd0;
      push_exp(1'b1, 8'd0, 1'b1);
      req1 = 1'b1;
      t = 0;
      observe(10, 1'b1, g_t, g_who, d_t, d_vec, en_seen, leak);
      checks++;
      if (g_t !== 1 || g_who !== 1 || d_t !== 1) begin
         errors++;
         $display("[TB] FAIL divz_timing: got gnt t=%0d who=%0d done t=%0d expected 1/1/1", g_t, g_who, d_t);
      end
      e_vec = pop_vec();
      checks++;
      if (d_vec !== e_vec) begin
         errors++;
         $display("[TB] FAIL divz_response: got %h expected %h", d_vec, e_vec);
      end
      checks++;
      if (en_seen !== 1'b0) begin
         errors++;
         $display("[TB] FAIL divz_alu_en: got %0d expected 0", en_seen);
      end
      tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL divz_busy_after: got %0d expected 0", busy);
      end
   endtask

   task automatic test_stale_timeout();
      int g_t, g_who, d_t;
      logic [VW-1:0] d_vec, e_vec;
      bit en_seen, leak;
      tick();
      stale = 1'b1; valid_at = 3;
      op0 = 2'd2; a0 = 4'd5; b0 = 4'd3;
      push_exp(1'b0, 8'd15, 1'b0);
      req0 = 1'b1;
      t = 0;
      observe(40, 1'b1, g_t, g_who, d_t, d_vec, en_seen, leak);
      checks++;
      if (d_t !== 4) begin
         errors++;
         $display("[TB] FAIL stale_done_time: got %0d expected 4", d_t);
      end
      e_vec = pop_vec();
      checks++;
      if (d_vec !== e_vec) begin
         errors++;
         $display("[TB] FAIL stale_response: got %h expected %h", d_vec, e_vec);
      end
      tick();
      stale = 1'b0; valid_at = 0;
      op0 = 2'd0; a0 = 4'd9; b0 = 4'd9;
      push_exp(1'b0, 8'd0, 1'b1);
      req0 = 1'b1;
      t = 0;
      observe(40, 1'b1, g_t, g_who, d_t, d_vec, en_seen, leak);
      checks++;
      if (d_t !== TO + 1 || (d_t - g_t) !== TO) begin
         errors++;
         $display("[TB] FAIL timeout_time: got gnt=%0d done=%0d expected gnt=1 done=%0d", g_t, d_t, TO + 1);
      end
      e_vec = pop_vec();
      checks++;
      if (d_vec !== e_vec) begin
         errors++;
         $display("[TB] FAIL timeout_response: got %h expected %h", d_vec, e_vec);
      end
      checks++;
      if (leak !== 1'b0) begin
         errors++;
         $display("[TB] FAIL timeout_res_leak: got %0d expected 0", leak);
      end
      valid_at = 2;
   endtask

   task automatic test_back_to_back();
      int g_t, g_who, d_t, d_first;
      logic [VW-1:0] d_vec, e_vec;
      bit en_seen, leak;
      tick();
      stale = 1'b0; valid_at = 2;
      op1 = 2'd3; a1 = 4'd8; b1 = 4'd2;
      push_exp(1'b1, 8'd4, 1'b0);
      push_exp(1'b1, 8'd4, 1'b0);
      req1 = 1'b1;
      t = 0;
      observe(40, 1'b0, g_t, g_who, d_t, d_vec, en_seen, leak);
      e_vec = pop_vec();
      checks++;
      if (d_t !== 3 || d_vec !== e_vec) begin
         errors++;
         $display("[TB] FAIL div_first: got t=%0d %h expected t=3 %h", d_t, d_vec, e_vec);
      end
      d_first = d_t;
      observe(40, 1'b1, g_t, g_who, d_t, d_vec, en_seen, leak);
      checks++;
      if (g_t !== d_first + 2 || g_who !== 1) begin
         errors++;
         $display("[TB] FAIL b2b_grant: got t=%0d who=%0d expected t=%0d who=1", g_t, g_who, d_first + 2);
      end
      e_vec = pop_vec();
      checks++;
      if (d_vec !== e_vec) begin
         errors++;
         $display("[TB] FAIL div_second: got %h expected %h", d_vec, e_vec);
      end
   endtask

   task automatic test_reset_mid_exec();
      int g_t, g_who, d_t;
      logic [VW-1:0] d_vec, e_vec;
      logic [VW+IN*2+4:0] outs;
      bit en_seen, leak, stray;
      tick();
      stale = 1'b0; valid_at = 5;
      op0 = 2'd0; a0 = 4'd3; b0 = 4'd3;
      req0 = 1'b1;
      t = 0;
      tick();
      checks++;
      if (gnt0 !== 1'b1 || alu_en !== 1'b1) begin
         errors++;
         $display("[TB] FAIL midrst_grant: got gnt0=%0d en=%0d expected 1/1", gnt0, alu_en);
      end
      req0 = 1'b0;
      tick();
      rst = 1'b0;
      #1;
      outs = {gnt0, gnt1, done0, done1, res0, res1, err0, err1, busy, alu_en, alu_op, alu_a, alu_b};
      checks++;
      if (outs !== '0) begin
         errors++;
         $display("[TB] FAIL midrst_outputs: got %h expected 0", outs);
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      stray = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (done0 || done1 || gnt0 || gnt1) stray = 1'b1;
      end
      checks++;
      if (stray !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midrst_no_done: got %0d expected 0", stray);
      end
      valid_at = 2;
      push_exp(1'b0, 8'd6, 1'b0);
      op1 = 2'd0; a1 = 4'd1; b1 = 4'd1;
      req0 = 1'b1; req1 = 1'b1;
      t = 0;
      observe(40, 1'b1, g_t, g_who, d_t, d_vec, en_seen, leak);
      req1 = 1'b0;
      checks++;
      if (g_who !== 0) begin
         errors++;
         $display("[TB] FAIL midrst_tie_grant: got %0d expected 0", g_who);
      end
      e_vec = pop_vec();
      checks++;
      if (d_vec !== e_vec) begin
         errors++;
         $display("[TB] FAIL midrst_response: got %h expected %h", d_vec, e_vec);
      end
      tick();
   endtask

   // Scenario sequence followed by the summary line.
   initial begin
      rst = 1'b0;
      req0 = 1'b0; req1 = 1'b0;
      op0 = '0; op1 = '0;
      a0 = '0; b0 = '0; a1 = '0; b1 = '0;
      alu_valid = 1'b0;
      alu_result = '0;
      test_reset();
      test_single_add();
      test_simultaneous();
      test_div_zero();
      test_stale_timeout();
      test_back_to_back();
      test_reset_mid_exec();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
